frame_buf_multi: RTL
====================

// Module: frame_buf_multi
// PURPOSE
//   Multi-buffer frame store (ping-pong for NUM_BUFS=2, triple-buffer for 3) between a pixel/sample
//   producer and consumer on one clock. Writer fills whole frames of FRAME_LEN words into a ring of
//   NUM_BUFS buffers; reader drains only committed frames, in order. Writer never touches a
//   buffer until it is fully drained; reader never sees a partial frame.
// PARAMETERS
//   DATA_WIDTH        32                          word width
//   FRAME_ADDR_WIDTH  3                           log2 of words per frame
//   FRAME_LEN         1 << FRAME_ADDR_WIDTH       words per frame (derived, do not override)
//   NUM_BUFS          2                           frame buffers in ring, >= 1
//   BUF_IDX_WIDTH     (NUM_BUFS>1)?$clog2(NUM_BUFS):1   buffer index width (derived)
//   CNT_WIDTH         $clog2(NUM_BUFS+1)          width of frames_ready (derived)
// PORTS
//   clk            in   1              single clock, all logic on posedge
//   reset          in   1              synchronous, active-high
//   wr_en          in   1              write request, active-high; word accepted when wr_en && wr_rdy
//   wr_data        in   DATA_WIDTH     write word
//   wr_rdy         out  1              a FREE/FILLING buffer is available at write index
//   wr_frame_done  out  1              1-cycle pulse: a frame was committed
//   overflow       out  1              1-cycle pulse: wr_en while !wr_rdy (word dropped)
//   rd_en          in   1              read request, active-high; accepted when rd_en && rd_rdy
//   rd_rdy         out  1              buffer at read index is committed
//   rd_data        out  DATA_WIDTH     read word
//   rd_data_valid  out  1              rd_data valid (1 cycle after accepted read)
//   rd_frame_done  out  1              1-cycle pulse, aligned with rd_data_valid of last word
//   frames_ready   out  CNT_WIDTH      committed, not-yet-freed frames (incl. one being drained)
// BEHAVIOUR
//   - Reset: w_idx=r_idx=0, wr_ptr=rd_ptr=0, count=0; outputs wr_rdy=1 (comb), rd_rdy=0,
//     rd_data_valid=0, rd_data=0, wr_frame_done=0, rd_frame_done=0, overflow=0, frames_ready=0.
//     Reset mid-frame discards all partial and committed frames; memory contents not cleared.
//   - wr_rdy = (count != NUM_BUFS); rd_rdy = (count != 0). Both combinational from count.
//   - Write accept: mem[{w_idx,wr_ptr}] <= wr_data; wr_ptr++. On wr_ptr==FRAME_LEN-1: wr_ptr<=0,
//     w_idx<=w_idx+1 wrapping NUM_BUFS-1 -> 0 (explicit compare, NUM_BUFS need not be power of 2),
//     commit=1, wr_frame_done pulses next cycle.
//   - Read accept: RAM read at {r_idx,rd_ptr}; rd_data/rd_data_valid registered, latency 1 cycle.
//     rd_ptr++; on rd_ptr==FRAME_LEN-1: rd_ptr<=0, r_idx wraps as w_idx, free=1,
//     rd_frame_done asserted with that word's rd_data_valid.
//   - count <= count + commit - free; commit and free same cycle -> count unchanged.
//     Freed buffer becomes writable next cycle; RAM read already sampled, no hazard.
//   - Gaps allowed on both sides (wr_en/rd_en low = hold pointers). Rejected rd_en: no effect, no flag.
//   - NUM_BUFS=1: degenerates to single frame; write blocked until frame fully drained.
//   - Read during-write same address impossible by construction (buffer ownership exclusive).
//   - FSM per side (package enums): WR_IDLE/WR_FILL, RD_IDLE/RD_DRAIN; FILL/DRAIN entered on first
//     accepted word, back to IDLE after last word. State visible only for debug; flow set by count.
// STRUCTURE
//   - Package frame_buf_pkg: wr/rd state enums, mem-addr composition function {idx,ptr}.
//   - Sub-module frame_buf_ram: simple dual-port sync RAM, depth NUM_BUFS*FRAME_LEN
//     (addr BUF_IDX_WIDTH+FRAME_ADDR_WIDTH), 1 write port, 1 registered read port, no reset on array.
//   - Top: pointers, ring indices, count, pulses, RAM instance.
// TESTING (DATA_WIDTH=32, FRAME_ADDR_WIDTH=3, NUM_BUFS=2 unless noted)
//   1 Reset then write 8 words 0..7 continuous -> wr_frame_done pulse cycle after 8th accept,
//     frames_ready=1, rd_rdy=1; read 8 -> data 0..7, valid 1 cycle after each rd_en, rd_frame_done on 7.
//   2 Write 16 words with no reads -> frames_ready=2, wr_rdy=0; 17th wr_en -> overflow pulse, word
//     dropped; after draining frame 0, next write lands in buffer 0 and frame 1 reads intact 8..15.
//   3 Concurrent: write frame N+1 while reading frame N, last write and last read same cycle ->
//     frames_ready unchanged, both done pulses, no data corruption over 10 frames (wrap of idx).
//   4 rd_en asserted with frames_ready=0 -> rd_data_valid stays 0, no pointer movement; random
//     wr_en/rd_en gaps (50% duty) over 20 frames -> output stream equals input stream in order.
//   5 Reset asserted after 5 words of frame and mid-read -> all outputs reset values next cycle,
//     frames_ready=0; subsequent frame 100..107 reads back exactly.
//   6 NUM_BUFS=3: fill 3 frames, wr_rdy=0; index wrap 2->0 verified; NUM_BUFS=1: write blocked until
//     last word of the single frame read.

Source files
------------

// File: rtl/frame_buf_pkg.sv
// Shared types and helpers for the multi-buffer frame store.
package frame_buf_pkg;

  typedef enum logic {
    WR_IDLE,
    WR_FILL
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_DRAIN
  } rd_state_t;

  // RAM address is the buffer index in the upper bits and the word pointer below it.
  function automatic logic [31:0] mem_addr(input logic [31:0] idx,
                                           input logic [31:0] ptr,
                                           input int          ptr_w);
    return (idx << ptr_w) | ptr;
  endfunction

endpackage

// File: rtl/frame_buf_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// The array itself is never reset; only the read register is.
module frame_buf_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port; output returns to zero on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/frame_buf_multi.sv
// Multi-buffer frame store: writer fills whole frames into a ring of NUM_BUFS
// buffers, reader drains only committed frames in order. Flow control comes
// solely from the committed-frame count; the per-side FSMs are debug state.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   WR_IDLE   | writer at word 0 of its current buffer
//   WR_FILL   | writer has accepted part of a frame
//   RD_IDLE   | reader at word 0 of its current buffer
//   RD_DRAIN  | reader has consumed part of a committed frame
module frame_buf_multi
  import frame_buf_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int FRAME_ADDR_WIDTH = 3,
  // Derived; do not override.
  parameter int FRAME_LEN        = 1 << FRAME_ADDR_WIDTH,
  parameter int NUM_BUFS         = 2,
  // Derived; do not override.
  parameter int BUF_IDX_WIDTH    = (NUM_BUFS > 1) ? $clog2(NUM_BUFS) : 1,
  parameter int CNT_WIDTH        = $clog2(NUM_BUFS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_rdy,
  output logic                  wr_frame_done,
  output logic                  overflow,
  input  logic                  rd_en,
  output logic                  rd_rdy,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_valid,
  output logic                  rd_frame_done,
  output logic [CNT_WIDTH-1:0]  frames_ready
);

  localparam int ADDR_WIDTH = BUF_IDX_WIDTH + FRAME_ADDR_WIDTH;
  localparam int DEPTH      = NUM_BUFS * FRAME_LEN;

  localparam logic [FRAME_ADDR_WIDTH-1:0] PTR_LAST = FRAME_ADDR_WIDTH'(FRAME_LEN - 1);
  localparam logic [BUF_IDX_WIDTH-1:0]    IDX_LAST = BUF_IDX_WIDTH'(NUM_BUFS - 1);
  localparam logic [CNT_WIDTH-1:0]        CNT_FULL = CNT_WIDTH'(NUM_BUFS);

  logic [FRAME_ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [BUF_IDX_WIDTH-1:0]    w_idx, r_idx;
  logic [CNT_WIDTH-1:0]        count;
  logic [ADDR_WIDTH-1:0]       wr_addr, rd_addr;

  logic wr_acc, rd_acc, commit, free;

  wr_state_t wr_state, wr_state_nxt;
  rd_state_t rd_state, rd_state_nxt;

  assign wr_rdy       = (count != CNT_FULL);
  assign rd_rdy       = (count != '0);
  assign frames_ready = count;

  assign wr_acc = wr_en && wr_rdy;
  assign rd_acc = rd_en && rd_rdy;
  assign commit = wr_acc && (wr_ptr == PTR_LAST);
  assign free   = rd_acc && (rd_ptr == PTR_LAST);

  assign wr_addr = ADDR_WIDTH'(mem_addr(32'(w_idx), 32'(wr_ptr), FRAME_ADDR_WIDTH));
  assign rd_addr = ADDR_WIDTH'(mem_addr(32'(r_idx), 32'(rd_ptr), FRAME_ADDR_WIDTH));

  // Write side: word pointer and ring index; index wraps by compare so NUM_BUFS need not be 2^n.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      w_idx  <= '0;
    end else if (wr_acc) begin
      if (wr_ptr == PTR_LAST) begin
        wr_ptr <= '0;
        w_idx  <= (w_idx == IDX_LAST) ? '0 : w_idx + BUF_IDX_WIDTH'(1);
      end else begin
        wr_ptr <= wr_ptr + FRAME_ADDR_WIDTH'(1);
      end
    end
  end

  // Read side: word pointer and ring index, same wrap rule as the writer.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      r_idx  <= '0;
    end else if (rd_acc) begin
      if (rd_ptr == PTR_LAST) begin
        rd_ptr <= '0;
        r_idx  <= (r_idx == IDX_LAST) ? '0 : r_idx + BUF_IDX_WIDTH'(1);
      end else begin
        rd_ptr <= rd_ptr + FRAME_ADDR_WIDTH'(1);
      end
    end
  end

  // Committed-frame count; simultaneous commit and free cancel out.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      case ({commit, free})
        2'b10:   count <= count + CNT_WIDTH'(1);
        2'b01:   count <= count - CNT_WIDTH'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered status pulses, each one cycle after the event that caused it.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_frame_done <= 1'b0;
      overflow      <= 1'b0;
      rd_data_valid <= 1'b0;
      rd_frame_done <= 1'b0;
    end else begin
      wr_frame_done <= commit;
      overflow      <= wr_en && !wr_rdy;
      rd_data_valid <= rd_acc;
      rd_frame_done <= free;
    end
  end

  // Debug FSM state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state <= WR_IDLE;
      rd_state <= RD_IDLE;
    end else begin
      wr_state <= wr_state_nxt;
      rd_state <= rd_state_nxt;
    end
  end

  // Debug FSM next-state: partial frame in progress vs. at frame boundary.
  always_comb begin
    wr_state_nxt = wr_state;
    rd_state_nxt = rd_state;
    case (wr_state)
      WR_IDLE: if (wr_acc && !commit) wr_state_nxt = WR_FILL;
      WR_FILL: if (commit)            wr_state_nxt = WR_IDLE;
      default:                        wr_state_nxt = WR_IDLE;
    endcase
    case (rd_state)
      RD_IDLE:  if (rd_acc && !free) rd_state_nxt = RD_DRAIN;
      RD_DRAIN: if (free)            rd_state_nxt = RD_IDLE;
      default:                       rd_state_nxt = RD_IDLE;
    endcase
  end

  frame_buf_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (wr_acc),
    .waddr (wr_addr),
    .wdata (wr_data),
    .re    (rd_acc),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule
